// File: rtl/exa_crosb_output_arbiter_multiprio.sv
// exa_crosb_output_arbiter_multiprio: per-output crossbar arbiter over inputs, priorities and VCs
//   clk, reset        clock, asynchronous active-high reset
//   i_request         bit i*(vc_num*prio_num)+p*vc_num+v: input i requests priority p, VC v
//   i_credit_avail    bit p*vc_num+v: downstream output VC has a credit
//   i_cts_input       input arbiter accepts the offer, held for the transfer
//   i_last            last beat of the transferring packet
//   o_grant           one-hot offered/connected input
//   o_input_sel       encoded o_grant
//   o_prio_sel        priority of the offer/connection
//   o_vc_sel          VC of the offer/connection
//   o_cts             offer or connection active
//   o_starve_boost    connection was picked by the starvation boost
module exa_crosb_output_arbiter_multiprio #(
   parameter int input_num     = 4,
   parameter int vc_num        = 3,
   parameter int prio_num      = 2,
   parameter int offer_timeout = 16,
   parameter int starve_limit  = 8,
   localparam int iw = input_num > 1 ? $clog2(input_num) : 1,
   localparam int pw = prio_num > 1 ? $clog2(prio_num) : 1,
   localparam int vw = vc_num > 1 ? $clog2(vc_num) : 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [input_num*vc_num*prio_num-1:0] i_request,
   input  logic [vc_num*prio_num-1:0]           i_credit_avail,
   input  logic                                i_cts_input,
   input  logic                                i_last,
   output logic [input_num-1:0]                o_grant,
   output logic [iw-1:0]                       o_input_sel,
   output logic [pw-1:0]                       o_prio_sel,
   output logic [vw-1:0]                       o_vc_sel,
   output logic                                o_cts,
   output logic                                o_starve_boost
);
   localparam int sw = starve_limit > 0 ? $clog2(starve_limit + 1) : 1;
   typedef enum logic [1:0] {IDLE, OFFER, XFER} state_t;
   state_t state;
   logic [iw-1:0] ptr [prio_num];
   logic [sw-1:0] starve_cnt;
   logic [prio_num-1:0][input_num-1:0] elig;
   logic [prio_num-1:0][input_num-1:0][vw-1:0] vc_of;
   logic [input_num-1:0] cand, grant_nx;
   logic [input_num-1:0][vw-1:0] cand_vc;
   logic [pw-1:0] top, low, cls;
   logic [iw-1:0] ptr_c, win_hi, win_lo, win;
   logic [vw-1:0] vc_hi, vc_lo, win_vc;
   logic any_elig, lower_pend, boost, hit_hi, req_bit, tmo, leave, take;

   always_comb begin
      elig = '0;
      vc_of = '0;
      // descending VC scan so the lowest eligible VC is the one kept
      for (int p = 0; p < prio_num; p++)
         for (int i = 0; i < input_num; i++)
            for (int v = vc_num - 1; v >= 0; v--)
               if (i_request[i*vc_num*prio_num + p*vc_num + v] && i_credit_avail[p*vc_num + v]) begin
                  elig[p][i] = 1'b1;
                  vc_of[p][i] = vw'(v);
               end
      any_elig = 1'b0;
      top = '0;
      low = '0;
      for (int p = 0; p < prio_num; p++)
         if (|elig[p]) begin
            if (!any_elig) low = pw'(p);
            top = pw'(p);
            any_elig = 1'b1;
         end
      lower_pend = low != top;
      boost = lower_pend && starve_cnt == sw'(starve_limit);
      cls = boost ? low : top;
      cand = '0;
      cand_vc = '0;
      ptr_c = '0;
      for (int p = 0; p < prio_num; p++)
         if (pw'(p) == cls) begin
            cand = elig[p];
            cand_vc = vc_of[p];
            ptr_c = ptr[p];
         end
      // round robin: lowest eligible input above the pointer, else wrap to the lowest eligible
      hit_hi = 1'b0;
      win_hi = '0;
      win_lo = '0;
      vc_hi = '0;
      vc_lo = '0;
      for (int i = input_num - 1; i >= 0; i--)
         if (cand[i]) begin
            win_lo = iw'(i);
            vc_lo = cand_vc[i];
            if (iw'(i) > ptr_c) begin
               hit_hi = 1'b1;
               win_hi = iw'(i);
               vc_hi = cand_vc[i];
            end
         end
      win = hit_hi ? win_hi : win_lo;
      win_vc = hit_hi ? vc_hi : vc_lo;
      grant_nx = '0;
      for (int i = 0; i < input_num; i++) grant_nx[i] = iw'(i) == win;
      req_bit = 1'b0;
      for (int i = 0; i < input_num; i++)
         for (int p = 0; p < prio_num; p++)
            for (int v = 0; v < vc_num; v++)
               if (iw'(i) == o_input_sel && pw'(p) == o_prio_sel && vw'(v) == o_vc_sel)
                  req_bit = i_request[i*vc_num*prio_num + p*vc_num + v];
      leave = (state == OFFER && (i_cts_input ? i_last : (!req_bit || tmo))) || (state == XFER && i_last);
      // a withdrawn offer moves the pointer past the offered input; a dropped request does not
      take = state == OFFER && (i_cts_input || (req_bit && tmo));
   end

   if (offer_timeout > 0) begin : g_tmo
      localparam int tw = $clog2(offer_timeout + 1);
      logic [tw-1:0] tcnt;
      always_ff @(posedge clk or posedge reset)
         if (reset) tcnt <= '0;
         else tcnt <= state == OFFER ? tcnt + 1'b1 : '0;
      assign tmo = state == OFFER && tcnt == tw'(offer_timeout - 1);
   end else begin : g_no_tmo
      assign tmo = 1'b0;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         o_grant <= '0;
         o_input_sel <= '0;
         o_prio_sel <= '0;
         o_vc_sel <= '0;
         o_cts <= 1'b0;
         o_starve_boost <= 1'b0;
         starve_cnt <= '0;
         for (int p = 0; p < prio_num; p++) ptr[p] <= iw'(input_num - 1);
      end else begin
         if (state == IDLE && any_elig) begin
            state <= OFFER;
            o_grant <= grant_nx;
            o_input_sel <= win;
            o_prio_sel <= cls;
            o_vc_sel <= win_vc;
            o_cts <= 1'b1;
            o_starve_boost <= boost;
            // a boost fires exactly at the limit, so the count never passes it
            starve_cnt <= (boost || !lower_pend) ? '0 : starve_cnt + 1'b1;
         end
         if (leave) begin
            state <= IDLE;
            o_grant <= '0;
            o_input_sel <= '0;
            o_prio_sel <= '0;
            o_vc_sel <= '0;
            o_cts <= 1'b0;
            o_starve_boost <= 1'b0;
         end else if (state == OFFER && i_cts_input) state <= XFER;
         for (int p = 0; p < prio_num; p++)
            if (take && pw'(p) == o_prio_sel) ptr[p] <= o_input_sel;
      end
endmodule

// File: tb/tb_exa_crosb_output_arbiter_multiprio.sv
// tb_exa_crosb_output_arbiter_multiprio: directed checks of the multi-priority output arbiter
module tb_exa_crosb_output_arbiter_multiprio;
   logic clk = 1'b0, reset = 1'b0;
   logic [23:0] i_request = '0;
   logic [5:0] i_credit_avail = '0;
   logic i_cts_input = 1'b0, i_last = 1'b0;
   logic [3:0] o_grant;
   logic [1:0] o_input_sel;
   logic o_prio_sel;
   logic [1:0] o_vc_sel;
   logic o_cts, o_starve_boost;
   int checks = 0, errors = 0;

   exa_crosb_output_arbiter_multiprio #(.offer_timeout(4), .starve_limit(2)) dut (
      .clk(clk), .reset(reset), .i_request(i_request), .i_credit_avail(i_credit_avail),
      .i_cts_input(i_cts_input), .i_last(i_last), .o_grant(o_grant), .o_input_sel(o_input_sel),
      .o_prio_sel(o_prio_sel), .o_vc_sel(o_vc_sel), .o_cts(o_cts), .o_starve_boost(o_starve_boost)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] rq(input int i, input int p, input int v);
      logic [23:0] r;
      r = '0;
      r[i*6 + p*3 + v] = 1'b1;
      return r;
   endfunction

   task automatic expect_offer(input string tag, input int inp, input int p, input int v, input int b);
      int n;
      n = 0;
      while (!o_cts && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_cts"}, 32'(o_cts), 1);
      chk({tag, "_grant"}, 32'(o_grant), 32'(1) << inp);
      chk({tag, "_isel"}, 32'(o_input_sel), inp);
      chk({tag, "_prio"}, 32'(o_prio_sel), p);
      chk({tag, "_vc"}, 32'(o_vc_sel), v);
      chk({tag, "_boost"}, 32'(o_starve_boost), b);
   endtask

   task automatic accept(input string tag, input int beats);
      tick();
      i_cts_input = 1'b1;
      for (int b = 1; b <= beats; b++) begin
         i_last = b == beats;
         tick();
         if (b < beats) chk({tag, "_xfer"}, 32'(o_cts), 1);
      end
      i_cts_input = 1'b0;
      i_last = 1'b0;
      chk({tag, "_idle"}, 32'(o_cts), 0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 reset = 1'b1;
      i_request = rq(0,0,0) | rq(1,0,0) | rq(2,0,0) | rq(3,0,0);
      i_credit_avail = 6'h3f;
      tick();
      tick();
      chk("rst_grant", 32'(o_grant), 0);
      chk("rst_cts", 32'(o_cts), 0);
      chk("rst_sel", 32'({o_input_sel, o_prio_sel, o_vc_sel}), 0);
      chk("rst_boost", 32'(o_starve_boost), 0);
      reset = 1'b0;
      tick();
      chk("latency", 32'(o_cts), 1);
      for (int k = 0; k < 5; k++) begin
         expect_offer("rr", k % 4, 0, 0, 0);
         accept("rr", 3);
      end
      i_request = rq(1,0,0) | rq(2,0,0) | rq(3,1,2);
      expect_offer("hi", 3, 1, 2, 0);
      accept("hi", 3);
      i_request = rq(1,0,0) | rq(2,0,0);
      expect_offer("lo1", 1, 0, 0, 0);
      accept("lo1", 2);
      expect_offer("lo2", 2, 0, 0, 0);
      accept("lo2", 1);
      i_request = rq(2,0,0) | rq(2,0,1);
      i_credit_avail = 6'b111110;
      expect_offer("vc", 2, 0, 1, 0);
      accept("vc", 1);
      i_credit_avail = '0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("nocred", 32'(o_cts), 0);
      end
      i_request = '0;
      i_credit_avail = 6'h3f;
      tick();
      i_request = rq(0,0,0) | rq(1,0,0);
      expect_offer("tmo0", 0, 0, 0, 0);
      for (int k = 2; k <= 4; k++) begin
         tick();
         chk("tmo_hold", 32'({o_cts, o_grant}), 32'h11);
      end
      tick();
      chk("tmo_wd", 32'(o_cts), 0);
      tick();
      chk("tmo_next", 32'({o_cts, o_grant}), 32'h12);
      accept("tmo1", 1);
      expect_offer("tmo2", 0, 0, 0, 0);
      accept("tmo2", 1);
      i_request = '0;
      tick();
      i_request = rq(0,1,0) | rq(1,1,0) | rq(3,0,0);
      expect_offer("st1", 0, 1, 0, 0);
      accept("st1", 1);
      expect_offer("st2", 1, 1, 0, 0);
      accept("st2", 1);
      expect_offer("st3", 3, 0, 0, 1);
      accept("st3", 1);
      expect_offer("st4", 0, 1, 0, 0);
      tick();
      i_cts_input = 1'b1;
      tick();
      chk("rx_xfer", 32'(o_cts), 1);
      tick();
      reset = 1'b1;
      #1;
      chk("rx_grant", 32'(o_grant), 0);
      chk("rx_cts", 32'(o_cts), 0);
      tick();
      i_cts_input = 1'b0;
      reset = 1'b0;
      tick();
      chk("rx_next", 32'({o_cts, o_grant, o_prio_sel, o_starve_boost}), 32'b1_0001_1_0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/exa_crosb_output_arbiter_multiprio.md
Name: exa_crosb_output_arbiter_multiprio

Overview:
Per-output arbiter for the Exanet crossbar, generalising the two-priority VC output arbiter to any number of priorities and VCs. Picks one (input, priority, VC) among requesting inputs whose target output VC has downstream credit, and offers it to the input arbiter. It holds the offer until the input arbiter accepts, then holds the connection until the packet's last beat. Adds per-priority round-robin, offer timeout/withdraw, and low-priority starvation boost.

Parameters:
input_num, 4, number of crossbar inputs competing for this output
vc_num, 3, virtual channels per priority
prio_num, 2, priority classes; higher index = higher priority
offer_timeout, 16, cycles an unaccepted offer is held before withdrawal; 0 = never withdraw
starve_limit, 8, consecutive decisions a pending lower class may lose before a boost

Ports:
clk  in  1  clock
reset  in  1  reset
i_request  in  input_num*vc_num*prio_num  bit i*(vc_num*prio_num)+p*vc_num+v = input i requests prio p, VC v
i_credit_avail  in  vc_num*prio_num  bit p*vc_num+v = downstream output VC has at least one credit
i_cts_input  in  1  input arbiter accepts the current offer; stays high for the transfer
i_last  in  1  last beat of the transferring packet
o_grant  out  input_num  one-hot offered/connected input
o_input_sel  out  clog2(input_num)  index of o_grant
o_prio_sel  out  clog2(prio_num)  priority of the connection
o_vc_sel  out  clog2(vc_num)  VC of the connection
o_cts  out  1  offer/connection active
o_starve_boost  out  1  current connection was chosen by starvation boost

Behaviour:
- Clock clk. Reset is asynchronous and active-high on port reset.
- Reset values: all outputs 0. FSM in IDLE. Every round-robin pointer = input_num-1, so the first search starts at input 0. Timeout and starvation counters = 0.
- Eligibility: (i,p) is eligible if any v has the request bit set and i_credit_avail[p*vc_num+v] high. VC chosen = lowest eligible v.
- FSM states: IDLE, OFFER, XFER.
- IDLE: if anything is eligible, register the decision and go to OFFER. Outputs appear in the next cycle, so request-to-grant latency is 1 cycle.
- Normal decision: highest p with any eligible input. Within that class, search from ptr[p]+1 upward, wrapping modulo input_num. The first eligible input wins.
- Boost decision: if starve_cnt == starve_limit, serve the lowest pending eligible class instead. Set o_starve_boost and clear starve_cnt.
- starve_cnt increments on each normal decision in which a lower class had eligible requests. It clears when a lower class is served. It saturates at starve_limit.
- OFFER: o_cts=1, o_grant/sel held stable; higher-priority arrivals are ignored.
  - i_cts_input=1: ptr[p] <= offered input. Go to XFER, or to IDLE if i_last is also 1 (single-beat packet).
  - Offered request bit drops (cts low): back to IDLE, outputs cleared next cycle, ptr unchanged.
  - Timeout counter reaches offer_timeout with no acceptance: withdraw to IDLE and set ptr[p] <= offered input, so the input is skipped next round. Acceptance and timeout in the same cycle: acceptance wins.
- XFER: outputs held. Request and credit changes are ignored. On i_last, go to IDLE and clear outputs next cycle. Minimum one IDLE cycle between connections.
- Timeout counter is clog2(offer_timeout+1) bits, cleared on entry to OFFER. With offer_timeout=0 the counter is absent and OFFER never times out.
- Pointers update only as stated. A class whose pointer sits at input_num-1 searches from 0.
- Reset asserted mid-OFFER or mid-XFER returns to reset values immediately. Nothing is restored.
- i_last outside XFER/OFFER is ignored. i_cts_input in IDLE is ignored.

Test Plan:
- Reset, then all inputs request prio0 VC0 with credit, cts each offer after 1 cycle, 3-beat packets -> grants 0,1,2,3,0 in order, o_prio_sel=0, o_vc_sel=0.
- Inputs 1 and 2 request prio0, input 3 requests prio1 VC2 -> input 3 first with o_prio_sel=1, o_vc_sel=2; prio0 order then resumes at input 1.
- Input 2 requests prio0 VC0 (no credit) and VC1 (credit) -> o_vc_sel=1. Clear all credit -> o_cts stays 0.
- offer_timeout=4, input 0 offered, i_cts_input never asserted, input 1 also requesting -> withdrawal after 4 OFFER cycles, then input 1 offered; input 0 offered again only after input 1 is served.
- starve_limit=2, prio1 always requesting, input 3 requesting prio0 -> third decision grants input 3 at prio0 with o_starve_boost=1, then prio1 resumes.
- Assert reset during XFER with i_cts_input high -> o_grant=0 and o_cts=0 immediately; the next grant after release is input 0.
